// File: rtl/rr_arb5_ctl.sv
// rr_arb5_ctl
//   Round-robin arbiter that shares one single-port resource among five
//   requesters. The grant is registered and one-hot. An owner can hold the
//   grant for at most MAX_HOLD consecutive cycles, and only while another
//   requester is waiting. An optional dead gap of GAP cycles separates two
//   owners.
//
// Parameters
//   MAX_HOLD  max consecutive grant cycles while others wait (0 = unlimited)
//   GAP       dead cycles between release and the next grant (0 = back-to-back)
//
// Ports
//   CK       in   1  clock, all state on the rising edge
//   CD       in   1  synchronous active-high reset
//   REQ      in   5  request per requester, held high while access is wanted
//   GNT      out  5  registered one-hot grant, all-zero when there is no owner
//   GNT_ID   out  3  index of the owner, 3'd7 when GNT is zero
//   BUSY     out  1  high while GNT is non-zero
//   IDLE     out  1  registered NOR of all request lines
//   PREEMPT  out  1  one-cycle pulse when MAX_HOLD forcibly removes the grant
module rr_arb5_ctl #(
   parameter int MAX_HOLD = 16,
   parameter int GAP      = 1
) (
   input  logic       CK,
   input  logic       CD,
   input  logic [4:0] REQ,
   output logic [4:0] GNT,
   output logic [2:0] GNT_ID,
   output logic       BUSY,
   output logic       IDLE,
   output logic       PREEMPT
);

   localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam int GAP_W  = (GAP < 1) ? 1 : $clog2(GAP + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
   localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

   state_t            state;
   logic [2:0]        ptr;
   logic [HOLD_W-1:0] hold_cnt;
   logic [GAP_W-1:0]  gap_cnt;

   logic       pick_found, rel_found;
   logic [2:0] pick_idx, rel_idx;
   logic       others_wait, preempt_now;

   // First requester found when scanning base+1, base+2, ... mod 5, so the
   // requester at `base` itself has the lowest priority.
   function automatic logic [3:0] arb_pick(input logic [4:0] req, input logic [2:0] base);
      logic       found;
      logic [2:0] idx;
      logic [2:0] j3;
      int         j;
      found = 1'b0;
      idx   = 3'd7;
      // Scan from the farthest candidate down so the nearest one wins.
      for (int k = 5; k >= 1; k--) begin
         j  = (int'(base) + k) % 5;
         j3 = 3'(j);
         if (req[j3]) begin
            found = 1'b1;
            idx   = j3;
         end
      end
      return {found, idx};
   endfunction

   // Two pick results: one from the stored pointer (idle / end of gap) and one
   // relative to the current owner, used when GAP=0 re-arbitrates on the very
   // edge the owner releases (the pointer is only updated at that same edge).
   always_comb begin
      {pick_found, pick_idx} = arb_pick(REQ, ptr);
      {rel_found, rel_idx}   = arb_pick(REQ, GNT_ID);
      others_wait = |(REQ & ~GNT);
      preempt_now = (MAX_HOLD != 0) && REQ[GNT_ID] && (hold_cnt >= HOLD_MAX) && others_wait;
   end

   always_ff @(posedge CK) begin
      if (CD) begin
         state    <= S_IDLE;
         ptr      <= 3'd4;
         hold_cnt <= '0;
         gap_cnt  <= '0;
         GNT      <= 5'b00000;
         GNT_ID   <= 3'd7;
         BUSY     <= 1'b0;
         IDLE     <= 1'b1;
         PREEMPT  <= 1'b0;
      end else begin
         IDLE    <= ~|REQ;
         PREEMPT <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_found) begin
                  GNT      <= 5'b00001 << pick_idx;
                  GNT_ID   <= pick_idx;
                  BUSY     <= 1'b1;
                  hold_cnt <= HOLD_W'(1);
                  state    <= S_GRANT;
               end
            end

            S_GRANT: begin
               if (!REQ[GNT_ID] || preempt_now) begin
                  // Owner released (or was forced off): it becomes lowest priority.
                  PREEMPT <= preempt_now;
                  ptr     <= GNT_ID;
                  if (GAP > 0) begin
                     GNT     <= 5'b00000;
                     GNT_ID  <= 3'd7;
                     BUSY    <= 1'b0;
                     gap_cnt <= GAP_W'(1);
                     state   <= S_GAP;
                  end else if (rel_found) begin
                     GNT      <= 5'b00001 << rel_idx;
                     GNT_ID   <= rel_idx;
                     BUSY     <= 1'b1;
                     hold_cnt <= HOLD_W'(1);
                     state    <= S_GRANT;
                  end else begin
                     GNT    <= 5'b00000;
                     GNT_ID <= 3'd7;
                     BUSY   <= 1'b0;
                     state  <= S_IDLE;
                  end
               end else if (hold_cnt < HOLD_MAX) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end

            S_GAP: begin
               if (gap_cnt >= GAP_LAST) begin
                  if (pick_found) begin
                     GNT      <= 5'b00001 << pick_idx;
                     GNT_ID   <= pick_idx;
                     BUSY     <= 1'b1;
                     hold_cnt <= HOLD_W'(1);
                     state    <= S_GRANT;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end

            default: begin
               GNT    <= 5'b00000;
               GNT_ID <= 3'd7;
               BUSY   <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arb5_ctl.sv
// tb_rr_arb5_ctl
//   Scenario bench for rr_arb5_ctl. dut_a uses MAX_HOLD=4, GAP=1; dut_b uses
//   the default MAX_HOLD=16 with GAP=0. Each step pushes the expected output
//   vector {GNT, GNT_ID, BUSY, IDLE, PREEMPT} when REQ/CD are driven and pops
//   it after the following rising edge.
module tb_rr_arb5_ctl;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       cd_a, cd_b;
   logic [4:0] req_a, req_b;
   logic [4:0] gnt_a, gnt_b;
   logic [2:0] id_a, id_b;
   logic       busy_a, busy_b, idle_a, idle_b, pre_a, pre_b;

   rr_arb5_ctl #(.MAX_HOLD(4), .GAP(1)) dut_a (
      .CK(clk), .CD(cd_a), .REQ(req_a), .GNT(gnt_a), .GNT_ID(id_a),
      .BUSY(busy_a), .IDLE(idle_a), .PREEMPT(pre_a)
   );

   rr_arb5_ctl #(.MAX_HOLD(16), .GAP(0)) dut_b (
      .CK(clk), .CD(cd_b), .REQ(req_b), .GNT(gnt_b), .GNT_ID(id_b),
      .BUSY(busy_b), .IDLE(idle_b), .PREEMPT(pre_b)
   );

   logic [10:0] obs_a, obs_b;
   assign obs_a = {gnt_a, id_a, busy_a, idle_a, pre_a};
   assign obs_b = {gnt_b, id_b, busy_b, idle_b, pre_b};

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [10:0] exp_q[$];
   logic [10:0] e;

   function automatic logic [2:0] id_of(input logic [4:0] g);
      case (g)
         5'b00001: return 3'd0;
         5'b00010: return 3'd1;
         5'b00100: return 3'd2;
         5'b01000: return 3'd3;
         5'b10000: return 3'd4;
         default:  return 3'd7;
      endcase
   endfunction

   function automatic logic [10:0] expv(input logic [4:0] g, input logic idle, input logic pre);
      return {g, id_of(g), (g != 5'b0), idle, pre};
   endfunction

   task automatic reset_a();
      cd_a  = 1'b1;
      req_a = 5'b0;
      @(posedge clk); #1;
      cd_a  = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0] rq[5] = '{5'h1F, 5'h1F, 5'h1F, 5'h00, 5'h00};
      logic       cv[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [4:0] eg[5] = '{5'h00, 5'h00, 5'h01, 5'h00, 5'h00};
      logic       ei[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
         cd_a  = cv[i];
         req_a = rq[i];
         exp_q.push_back(expv(eg[i], ei[i], 1'b0));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         n_checks++;
         if (obs_a !== e) begin
            n_fail++;
            $display("FAIL reset step %0d: got %b required %b", i, obs_a, e);
         end
      end
   endtask

   task automatic test_single();
      logic [4:0] rq[5] = '{5'h04, 5'h04, 5'h00, 5'h00, 5'h00};
      logic [4:0] eg[5] = '{5'h04, 5'h04, 5'h00, 5'h00, 5'h00};
      reset_a();
      for (int i = 0; i < 5; i++) begin
         req_a = rq[i];
         exp_q.push_back(expv(eg[i], (rq[i] == 5'h0), 1'b0));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         n_checks++;
         if (obs_a !== e) begin
            n_fail++;
            $display("FAIL single step %0d: got %b required %b", i, obs_a, e);
         end
      end
   endtask

   task automatic test_fairness();
      int owners[6] = '{0, 1, 2, 3, 4, 0};
      logic [4:0] oh;
      reset_a();
      for (int n = 0; n < 6; n++) begin
         oh = 5'b00001 << owners[n];
         for (int c = 0; c < 4; c++) begin
            // Three granted cycles, then the owner drops its request for one edge.
            req_a = (c == 3) ? (5'h1F & ~oh) : 5'h1F;
            exp_q.push_back(expv((c == 3) ? 5'h00 : oh, 1'b0, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if (obs_a !== e) begin
               n_fail++;
               $display("FAIL fairness owner %0d cyc %0d: got %b required %b", owners[n], c, obs_a, e);
            end
         end
      end
   endtask

   task automatic test_preempt();
      logic [4:0] rq[8] = '{5'h02, 5'h02, 5'h0A, 5'h0A, 5'h0A, 5'h0A, 5'h00, 5'h00};
      logic [4:0] eg[8] = '{5'h02, 5'h02, 5'h02, 5'h02, 5'h00, 5'h08, 5'h00, 5'h00};
      logic       ep[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      reset_a();
      for (int i = 0; i < 8; i++) begin
         req_a = rq[i];
         exp_q.push_back(expv(eg[i], (rq[i] == 5'h0), ep[i]));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         n_checks++;
         if (obs_a !== e) begin
            n_fail++;
            $display("FAIL preempt step %0d: got %b required %b", i, obs_a, e);
         end
      end
   endtask

   task automatic test_solo_hold();
      reset_a();
      for (int i = 0; i < 22; i++) begin
         req_a = (i < 20) ? 5'h04 : 5'h00;
         exp_q.push_back(expv((i < 20) ? 5'h04 : 5'h00, (i >= 20), 1'b0));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         n_checks++;
         if (obs_a !== e) begin
            n_fail++;
            $display("FAIL solo_hold step %0d: got %b required %b", i, obs_a, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic       cv[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [4:0] rq[8] = '{5'h08, 5'h08, 5'h1F, 5'h1F, 5'h1E, 5'h1C, 5'h00, 5'h00};
      logic [4:0] eg[8] = '{5'h08, 5'h08, 5'h00, 5'h01, 5'h02, 5'h04, 5'h00, 5'h00};
      for (int i = 0; i < 8; i++) begin
         cd_b  = cv[i];
         req_b = rq[i];
         exp_q.push_back(expv(eg[i], cv[i] | (rq[i] == 5'h0), 1'b0));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         n_checks++;
         if (obs_b !== e) begin
            n_fail++;
            $display("FAIL back_to_back step %0d: got %b required %b", i, obs_b, e);
         end
      end
   endtask

   initial begin
      cd_a  = 1'b1;
      cd_b  = 1'b1;
      req_a = 5'h00;
      req_b = 5'h00;
      test_reset();
      test_single();
      test_fairness();
      test_preempt();
      test_solo_hold();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
